// File: rtl/parser_pkg.sv
`default_nettype none
// ============================================================================
// parser_pkg
// ----------------------------------------------------------------------------
// Shared definitions for the parser/deparser datapath.
//   - Default widths: data, tuser, PHV length, queue-select field position.
//   - Queue count and the index width derived from it.
//   - Merger state enum {IDLE, SEND}.
//   - onehot_to_idx(): returns the lowest set bit of a queue-select field.
//     An all-zero field maps to queue 0.
// Revision: 1.0 - initial release
// ============================================================================
package parser_pkg;

  localparam int DEF_DATA_WIDTH      = 256;
  localparam int DEF_TUSER_WIDTH     = 128;
  localparam int DEF_PKT_HDR_LEN     = 1024;
  localparam int DEF_QSEL_LSB        = 141;
  localparam int DEF_QSEL_FIFO_DEPTH = 16;
  localparam int NUM_QUEUES          = 4;
  localparam int QSEL_W              = NUM_QUEUES;
  localparam int QIDX_W              = 2;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } merge_state_t;

  typedef logic [QSEL_W-1:0] qsel_t;
  typedef logic [QIDX_W-1:0] qidx_t;

  // Scan from the top down so the last match is the lowest set bit.
  function automatic qidx_t onehot_to_idx(input qsel_t oh);
    qidx_t idx;
    idx = '0;
    for (int i = NUM_QUEUES - 1; i >= 0; i--) begin
      if (oh[i]) idx = qidx_t'(i);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pkt_queue_merger_qsel_fifo.sv
`default_nettype none
// ============================================================================
// qsel_fifo
// ----------------------------------------------------------------------------
// Synchronous FIFO holding queue selects in PHV arrival order.
// Pointers carry one extra MSB so full and empty can be told apart when the
// index bits are equal.
// Ports:
//   axis_clk, aresetn  clock, synchronous active-low reset
//   push, din          write request and data
//   pop                read request (ignored when empty)
//   dout               head entry (valid when !empty)
//   full, empty        occupancy flags
//   drop               pulse: push refused because full and no pop
// A push into a full FIFO succeeds when a pop happens in the same cycle.
// Revision: 1.0 - initial release
// ============================================================================
module qsel_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 4
) (
  input  logic             axis_clk,
  input  logic             aresetn,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic             drop
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && !do_push;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge axis_clk) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge axis_clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/pkt_queue_merger.sv
`default_nettype none
// ============================================================================
// pkt_queue_merger
// ----------------------------------------------------------------------------
// Merges four packet data cache queues into one AXI-Stream toward the
// deparser. Each PHV strobe queues the one-hot select at
// phv_in[QSEL_LSB+:4]; packets are then drained whole, one per select, in
// PHV arrival order.
// Ports:
//   axis_clk, aresetn    clock, synchronous active-low reset
//   phv_in, phv_in_valid header vector and its single-cycle strobe
//   s_axis_*_q           four packed input queues (q0 in the LSBs)
//   s_axis_tready_q      per-queue ready, only the selected queue is driven
//   m_axis_*             merged output stream
//   qsel_overflow        sticky: select dropped because the FIFO was full
//   qsel_err             sticky: non-one-hot select seen (checked build only)
// Build option: define QSEL_CHECK_EN to discard selects whose popcount is
// not 1 and flag them on qsel_err. Without it selects are pushed unchecked
// and the lowest set bit (queue 0 for an all-zero field) picks the queue.
// Revision: 1.0 - initial release
// ============================================================================
module pkt_queue_merger
  import parser_pkg::*;
#(
  parameter int C_S_AXIS_DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int C_S_AXIS_TUSER_WIDTH = DEF_TUSER_WIDTH,
  parameter int PKT_HDR_LEN          = DEF_PKT_HDR_LEN,
  parameter int QSEL_LSB             = DEF_QSEL_LSB,
  parameter int QSEL_FIFO_DEPTH      = DEF_QSEL_FIFO_DEPTH
) (
  input  logic                                             axis_clk,
  input  logic                                             aresetn,
  input  logic [PKT_HDR_LEN-1:0]                           phv_in,
  input  logic                                             phv_in_valid,
  input  logic [NUM_QUEUES*C_S_AXIS_DATA_WIDTH-1:0]        s_axis_tdata_q,
  input  logic [NUM_QUEUES*C_S_AXIS_TUSER_WIDTH-1:0]       s_axis_tuser_q,
  input  logic [NUM_QUEUES*(C_S_AXIS_DATA_WIDTH/8)-1:0]    s_axis_tkeep_q,
  input  logic [NUM_QUEUES-1:0]                            s_axis_tlast_q,
  input  logic [NUM_QUEUES-1:0]                            s_axis_tvalid_q,
  output logic [NUM_QUEUES-1:0]                            s_axis_tready_q,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]                   m_axis_tdata,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]                  m_axis_tuser,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]                 m_axis_tkeep,
  output logic                                             m_axis_tlast,
  output logic                                             m_axis_tvalid,
  input  logic                                             m_axis_tready,
  output logic                                             qsel_overflow,
  output logic                                             qsel_err
);

  localparam int KW = C_S_AXIS_DATA_WIDTH / 8;

  // Per-queue views of the packed input buses.
  logic [C_S_AXIS_DATA_WIDTH-1:0]  q_tdata [NUM_QUEUES];
  logic [C_S_AXIS_TUSER_WIDTH-1:0] q_tuser [NUM_QUEUES];
  logic [KW-1:0]                   q_tkeep [NUM_QUEUES];

  for (genvar q = 0; q < NUM_QUEUES; q++) begin : g_unpack
    assign q_tdata[q] = s_axis_tdata_q[q*C_S_AXIS_DATA_WIDTH +: C_S_AXIS_DATA_WIDTH];
    assign q_tuser[q] = s_axis_tuser_q[q*C_S_AXIS_TUSER_WIDTH +: C_S_AXIS_TUSER_WIDTH];
    assign q_tkeep[q] = s_axis_tkeep_q[q*KW +: KW];
  end

  qsel_t        field;
  logic         field_ok;
  logic         fifo_push;
  logic         fifo_pop;
  qsel_t        fifo_dout;
  logic         fifo_full;
  logic         fifo_empty;
  logic         fifo_drop;
  merge_state_t state;
  qidx_t        cur_sel;
  logic         sel_valid;
  logic         sel_last;
  logic         beat_eop;
  logic         unused_bits;

  assign field = phv_in[QSEL_LSB +: QSEL_W];

  // Only the select field of the PHV matters here; full only feeds drop.
  assign unused_bits = ^{phv_in, fifo_full};

`ifdef QSEL_CHECK_EN
  assign field_ok = ($countones(field) == 1);

  always_ff @(posedge axis_clk) begin
    if (!aresetn) begin
      qsel_err <= 1'b0;
    end else if (phv_in_valid && !field_ok) begin
      qsel_err <= 1'b1;
    end
  end
`else
  assign field_ok = 1'b1;
  assign qsel_err = 1'b0;
`endif

  assign fifo_push = phv_in_valid && field_ok;

  qsel_fifo #(
    .DEPTH (QSEL_FIFO_DEPTH),
    .WIDTH (QSEL_W)
  ) u_qsel_fifo (
    .axis_clk (axis_clk),
    .aresetn  (aresetn),
    .push     (fifo_push),
    .din      (field),
    .pop      (fifo_pop),
    .dout     (fifo_dout),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .drop     (fifo_drop)
  );

  assign sel_valid = s_axis_tvalid_q[cur_sel];
  assign sel_last  = s_axis_tlast_q[cur_sel];
  assign beat_eop  = (state == SEND) && sel_valid && m_axis_tready && sel_last;

  // Popping on the last beat lets the next packet start on the very next
  // cycle, so packet boundaries cost no bubble.
  assign fifo_pop  = !fifo_empty && ((state == IDLE) || beat_eop);

  always_ff @(posedge axis_clk) begin
    if (!aresetn) begin
      state         <= IDLE;
      cur_sel       <= '0;
      qsel_overflow <= 1'b0;
    end else begin
      if (fifo_drop) qsel_overflow <= 1'b1;
      if (fifo_pop)  cur_sel       <= onehot_to_idx(fifo_dout);
      case (state)
        IDLE: begin
          if (!fifo_empty) state <= SEND;
        end
        SEND: begin
          if (beat_eop && fifo_empty) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Straight mux on the registered select: outputs stay stable during a
  // stall because cur_sel only moves on an accepted last beat.
  always_comb begin
    s_axis_tready_q = '0;
    m_axis_tdata    = q_tdata[cur_sel];
    m_axis_tuser    = q_tuser[cur_sel];
    m_axis_tkeep    = q_tkeep[cur_sel];
    m_axis_tvalid   = 1'b0;
    m_axis_tlast    = 1'b0;
    if (state == SEND) begin
      s_axis_tready_q[cur_sel] = m_axis_tready;
      m_axis_tvalid            = sel_valid;
      m_axis_tlast             = sel_last;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pkt_queue_merger.sv
`default_nettype none
// ============================================================================
// tb_pkt_queue_merger
// ----------------------------------------------------------------------------
// Self-checking bench for pkt_queue_merger. The reference model is a list of
// expected queue indices in PHV order plus, per queue, the beats of every
// packet that should leave; the merged stream must equal those packets
// concatenated in PHV order.
// Revision: 1.0 - initial release
// ============================================================================
module tb_pkt_queue_merger;

  localparam int DW = 32;
  localparam int UW = 16;
  localparam int KW = DW / 8;
  localparam int HL = 1024;
  localparam int QL = 141;
  localparam int FD = 16;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [UW-1:0] user;
    logic [KW-1:0] keep;
    logic          last;
  } beat_t;

  typedef struct {
    logic [3:0] field;
    int         exp_q;
    bit         exp_err;
  } vec_t;

  logic              axis_clk = 1'b0;
  logic              aresetn  = 1'b0;
  logic [HL-1:0]     phv_in = '0;
  logic              phv_in_valid = 1'b0;
  logic [4*DW-1:0]   s_axis_tdata_q = '0;
  logic [4*UW-1:0]   s_axis_tuser_q = '0;
  logic [4*KW-1:0]   s_axis_tkeep_q = '0;
  logic [3:0]        s_axis_tlast_q = '0;
  logic [3:0]        s_axis_tvalid_q = '0;
  logic [3:0]        s_axis_tready_q;
  logic [DW-1:0]     m_axis_tdata;
  logic [UW-1:0]     m_axis_tuser;
  logic [KW-1:0]     m_axis_tkeep;
  logic              m_axis_tlast;
  logic              m_axis_tvalid;
  logic              m_axis_tready = 1'b1;
  logic              qsel_overflow;
  logic              qsel_err;

  always #5 axis_clk = ~axis_clk;

  pkt_queue_merger #(
    .C_S_AXIS_DATA_WIDTH  (DW),
    .C_S_AXIS_TUSER_WIDTH (UW),
    .PKT_HDR_LEN          (HL),
    .QSEL_LSB             (QL),
    .QSEL_FIFO_DEPTH      (FD)
  ) dut (
    .axis_clk        (axis_clk),
    .aresetn         (aresetn),
    .phv_in          (phv_in),
    .phv_in_valid    (phv_in_valid),
    .s_axis_tdata_q  (s_axis_tdata_q),
    .s_axis_tuser_q  (s_axis_tuser_q),
    .s_axis_tkeep_q  (s_axis_tkeep_q),
    .s_axis_tlast_q  (s_axis_tlast_q),
    .s_axis_tvalid_q (s_axis_tvalid_q),
    .s_axis_tready_q (s_axis_tready_q),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tuser    (m_axis_tuser),
    .m_axis_tkeep    (m_axis_tkeep),
    .m_axis_tlast    (m_axis_tlast),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tready   (m_axis_tready),
    .qsel_overflow   (qsel_overflow),
    .qsel_err        (qsel_err)
  );

  // Model state
  beat_t srcq [4][$];   // beats each upstream queue still has to offer
  beat_t expq [4][$];   // beats expected to leave, per source queue
  int    exp_order[$];  // source queue of each expected packet, PHV order
  bit    pres [4];      // beat shown last cycle and not taken: must persist
  bit    hold_pend;
  beat_t held;
  int    nvec = 0;
  int    nmis = 0;
  int    cyc = 0;
  int    out_beats, out_lasts, first_cyc, last_cyc;
  int    vld_pct = 100;
  int    rdy_pct = 100;
  int    rdy_pat[$];
  int    pktcnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add_pkt(input int q, input int nb, input bit expd);
    beat_t b;
    pktcnt++;
    for (int i = 0; i < nb; i++) begin
      b.data = {4'(q), 12'(pktcnt), 16'(i)};
      b.user = UW'($urandom);
      b.keep = KW'($urandom);
      b.last = (i == nb - 1);
      srcq[q].push_back(b);
      if (expd) expq[q].push_back(b);
    end
  endtask

  // One clock cycle: drive at the falling edge, check 1 ns later, commit
  // handshakes at the rising edge. exp_q < 0 means the select must not be
  // accepted by the DUT.
  task automatic step(input bit pv, input logic [3:0] fld, input int exp_q);
    logic [HL-1:0] phv;
    bit    in_hs [4];
    bit    out_hs;
    beat_t ob;
    beat_t sb;
    beat_t eb;
    int    front;
    int    r;
    for (int i = 0; i < HL / 32; i++) phv[i*32 +: 32] = $urandom;
    phv[QL +: 4] = fld;
    phv_in       = phv;
    phv_in_valid = pv;
    if (pv && exp_q >= 0) exp_order.push_back(exp_q);
    for (int q = 0; q < 4; q++) begin
      if (srcq[q].size() > 0 && (pres[q] || $urandom_range(99) < vld_pct)) begin
        sb = srcq[q][0];
        s_axis_tvalid_q[q] = 1'b1;
        s_axis_tdata_q[q*DW +: DW] = sb.data;
        s_axis_tuser_q[q*UW +: UW] = sb.user;
        s_axis_tkeep_q[q*KW +: KW] = sb.keep;
        s_axis_tlast_q[q] = sb.last;
      end else begin
        s_axis_tvalid_q[q] = 1'b0;
        s_axis_tdata_q[q*DW +: DW] = DW'($urandom);
        s_axis_tuser_q[q*UW +: UW] = UW'($urandom);
        s_axis_tkeep_q[q*KW +: KW] = KW'($urandom);
        s_axis_tlast_q[q] = 1'($urandom_range(1));
      end
    end
    if (rdy_pat.size() > 0) begin
      r = rdy_pat.pop_front();
      m_axis_tready = (r != 0);
    end else begin
      m_axis_tready = ($urandom_range(99) < rdy_pct);
    end
    #1;
    ob = {m_axis_tdata, m_axis_tuser, m_axis_tkeep, m_axis_tlast};
    if (hold_pend) chk("hold_stable", {m_axis_tvalid, ob}, {1'b1, held});
    hold_pend = m_axis_tvalid && !m_axis_tready;
    held      = ob;
    front = (exp_order.size() > 0) ? exp_order[0] : -1;
    for (int q = 0; q < 4; q++) begin
      if (q != front) chk($sformatf("tready_q%0d_unselected", q), s_axis_tready_q[q], 1'b0);
      in_hs[q] = s_axis_tvalid_q[q] && s_axis_tready_q[q];
    end
    if (front < 0) chk("tvalid_no_packet", m_axis_tvalid, 1'b0);
    out_hs = m_axis_tvalid && m_axis_tready;
    if (out_hs) begin
      if (front < 0 || expq[front].size() == 0) begin
        nvec++;
        nmis++;
        $display("FAIL unexpected_beat: got 0x%0h, required no beat (t=%0t)", ob, $time);
      end else begin
        eb = expq[front].pop_front();
        chk("out_beat", ob, eb);
        if (eb.last) void'(exp_order.pop_front());
      end
      out_beats++;
      if (m_axis_tlast) out_lasts++;
      if (first_cyc < 0) first_cyc = cyc;
      last_cyc = cyc;
    end
    for (int q = 0; q < 4; q++) pres[q] = s_axis_tvalid_q[q] && !in_hs[q];
    @(posedge axis_clk);
    cyc++;
    for (int q = 0; q < 4; q++) if (in_hs[q]) void'(srcq[q].pop_front());
    @(negedge axis_clk);
    phv_in_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_order.size() > 0 && n < budget) begin
      step(1'b0, 4'b0000, -1);
      n++;
    end
    chk("drain_pending_pkts", exp_order.size(), 0);
  endtask

  // One-cycle reset pulse with reset-value checks while aresetn is low.
  task automatic do_reset();
    aresetn         = 1'b0;
    phv_in_valid    = 1'b0;
    s_axis_tvalid_q = '0;
    m_axis_tready   = 1'b1;
    @(posedge axis_clk);
    #1;
    chk("rst_tready", s_axis_tready_q, 4'b0000);
    chk("rst_tvalid", m_axis_tvalid, 1'b0);
    chk("rst_tlast", m_axis_tlast, 1'b0);
    chk("rst_overflow", qsel_overflow, 1'b0);
    chk("rst_err", qsel_err, 1'b0);
    @(negedge axis_clk);
    aresetn = 1'b1;
    for (int q = 0; q < 4; q++) begin
      srcq[q].delete();
      expq[q].delete();
      pres[q] = 1'b0;
    end
    exp_order.delete();
    rdy_pat.delete();
    hold_pend = 1'b0;
    out_beats = 0;
    out_lasts = 0;
    first_cyc = -1;
    last_cyc  = -1;
    vld_pct   = 100;
    rdy_pct   = 100;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [8];
    int   sels[$];
    int   c0, q, base, n, dropq;

    tbl[0] = '{4'b0001, 0, 1'b0};
    tbl[1] = '{4'b0010, 1, 1'b0};
    tbl[2] = '{4'b0100, 2, 1'b0};
    tbl[3] = '{4'b1000, 3, 1'b0};
`ifdef QSEL_CHECK_EN
    tbl[4] = '{4'b0110, -1, 1'b1};
    tbl[5] = '{4'b0000, -1, 1'b1};
    tbl[6] = '{4'b1111, -1, 1'b1};
    tbl[7] = '{4'b1010, -1, 1'b1};
`else
    tbl[4] = '{4'b0110, 1, 1'b0};
    tbl[5] = '{4'b0000, 0, 1'b0};
    tbl[6] = '{4'b1111, 0, 1'b0};
    tbl[7] = '{4'b1010, 1, 1'b0};
`endif

    // Select decode table: every queue holds a packet, only one may drain.
    for (int i = 0; i < 8; i++) begin
      do_reset();
      step(1'b1, tbl[i].field, tbl[i].exp_q);
      for (int k = 0; k < 4; k++) add_pkt(k, 2, k == tbl[i].exp_q);
      drain(20);
      repeat (5) step(1'b0, 4'b0000, -1);
      chk($sformatf("tbl%0d_err", i), qsel_err, tbl[i].exp_err);
      chk($sformatf("tbl%0d_beats", i), out_beats, (tbl[i].exp_q >= 0) ? 2 : 0);
    end

    // One-packet routing with the other queues holding data.
    do_reset();
    c0 = cyc;
    step(1'b1, 4'b0100, 2);
    add_pkt(2, 3, 1'b1);
    add_pkt(0, 2, 1'b0);
    add_pkt(1, 2, 1'b0);
    add_pkt(3, 2, 1'b0);
    drain(20);
    repeat (4) step(1'b0, 4'b0000, -1);
    chk("route_first_latency", first_cyc - c0, 2);
    chk("route_beats", out_beats, 3);
    chk("route_lasts", out_lasts, 1);

    // Ordering and back-to-back packets: data arrives on queues 3, 0, 1.
    do_reset();
    add_pkt(3, 3, 1'b1);
    step(1'b1, 4'b0001, 0);
    step(1'b1, 4'b1000, 3);
    step(1'b1, 4'b0010, 1);
    step(1'b0, 4'b0000, -1);
    step(1'b0, 4'b0000, -1);
    add_pkt(0, 2, 1'b1);
    add_pkt(1, 2, 1'b1);
    drain(30);
    chk("nobubble_span", last_cyc - first_cyc + 1, 7);
    chk("nobubble_beats", out_beats, 7);

    // Back-pressure mid-packet: ready 1,0,0,1 around the second beat.
    do_reset();
    rdy_pat = '{1, 1, 1, 0, 0, 1, 1, 1};
    step(1'b1, 4'b0010, 1);
    add_pkt(1, 4, 1'b1);
    drain(20);
    chk("bp_beats", out_beats, 4);
    chk("bp_span", last_cyc - first_cyc + 1, 6);

    // Overflow: first select moves straight into the FSM, 16 fill the FIFO,
    // the 18th is dropped.
    do_reset();
    for (int i = 0; i < 18; i++) begin
      q = $urandom_range(3);
      step(1'b1, 4'b0001 << q, (i < 17) ? q : -1);
      if (i < 17) sels.push_back(q);
      else dropq = q;
      if (i == 16) chk("ovf_after_17", qsel_overflow, 1'b0);
    end
    chk("ovf_after_18", qsel_overflow, 1'b1);
    foreach (sels[i]) add_pkt(sels[i], $urandom_range(1, 2), 1'b1);
    add_pkt(dropq, 1, 1'b0);
    drain(200);
    repeat (8) step(1'b0, 4'b0000, -1);
    chk("ovf_pkts_drained", out_lasts, 17);
    chk("ovf_sticky", qsel_overflow, 1'b1);

    // Reset mid-packet with a second select still queued.
    base = out_beats;
    step(1'b1, 4'b0001, 0);
    step(1'b1, 4'b0100, 2);
    add_pkt(0, 4, 1'b1);
    n = 0;
    while (out_beats - base < 2 && n < 20) begin
      step(1'b0, 4'b0000, -1);
      n++;
    end
    chk("rstmid_beats_before", out_beats - base, 2);
    do_reset();
    for (int k = 0; k < 4; k++) add_pkt(k, 2, 1'b0);
    repeat (6) step(1'b0, 4'b0000, -1);
    chk("rstmid_no_drain", out_beats, 0);

    // Randomized traffic against the model.
    do_reset();
    vld_pct = 70;
    rdy_pct = 70;
    for (int c = 0; c < 400; c++) begin
      if (exp_order.size() < 12 && $urandom_range(99) < 30) begin
        q = $urandom_range(3);
        add_pkt(q, $urandom_range(1, 5), 1'b1);
        step(1'b1, 4'b0001 << q, q);
      end else begin
        step(1'b0, 4'b0000, -1);
      end
    end
    vld_pct = 100;
    rdy_pct = 100;
    drain(500);
    chk("rand_overflow", qsel_overflow, 1'b0);
    chk("rand_err", qsel_err, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
`default_nettype wire
